// File: rtl/gray_wptr_gen.sv
// Write-side pointer generator for an asynchronous FIFO: binary/Gray write pointer,
// two-flop read-pointer synchronizer, and registered full / almost-full / level status.
module gray_wptr_gen #(
    parameter int ADDR_WIDTH   = 8,
    parameter int AFULL_THRESH = (1 << ADDR_WIDTH) - 2
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH:0]   rd_ptr_gray_async,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH:0]   wptr_gray,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   wr_level
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_THRESH);

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PW-1:0] wbin_q;
    logic [PW-1:0] wptr_gray_q;
    logic [PW-1:0] sync1_q;
    logic [PW-1:0] sync2_q;
    logic          full_q;
    logic          afull_q;
    logic [PW-1:0] level_q;

    logic          wr_en_s;
    logic [PW-1:0] wbin_d;
    logic [PW-1:0] gray_d;
    logic [PW-1:0] rbin_s;
    logic [PW-1:0] level_d;
    logic          full_d;
    logic          afull_d;

    // Accept decision, next pointers and next status from the synchronized read pointer.
    always_comb begin
        wr_en_s = wr_req & ~full_q & sys_rst_n;
        wbin_d  = wbin_q + {{ADDR_WIDTH{1'b0}}, wr_en_s};
        gray_d  = bin2gray(wbin_d);
        rbin_s  = gray2bin(sync2_q);
        level_d = wbin_d - rbin_s;
        // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
        full_d  = (gray_d == {~sync2_q[PW-1:PW-2], sync2_q[PW-3:0]});
        afull_d = (level_d >= AFULL_LVL);
    end

    // Pointer, synchronizer and status registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wbin_q      <= {PW{1'b0}};
            wptr_gray_q <= {PW{1'b0}};
            sync1_q     <= {PW{1'b0}};
            sync2_q     <= {PW{1'b0}};
            full_q      <= 1'b0;
            afull_q     <= 1'b0;
            level_q     <= {PW{1'b0}};
        end else begin
            wbin_q      <= wbin_d;
            wptr_gray_q <= gray_d;
            sync1_q     <= rd_ptr_gray_async;
            sync2_q     <= sync1_q;
            full_q      <= full_d;
            afull_q     <= afull_d;
            level_q     <= level_d;
        end
    end

    assign wr_en       = wr_en_s;
    assign waddr       = wbin_q[ADDR_WIDTH-1:0];
    assign wptr_gray   = wptr_gray_q;
    assign full        = full_q;
    assign almost_full = afull_q;
    assign wr_level    = level_q;

endmodule

// File: tb/tb_gray_wptr_gen.sv
// Directed and randomized checks of gray_wptr_gen (ADDR_WIDTH=2) against a
// counting reference model of writes, reads and the two-edge synchronizer delay.
module tb_gray_wptr_gen;

    localparam int AW    = 2;
    localparam int PW    = AW + 1;
    localparam int DEPTH = 1 << AW;
    localparam int LAP   = 2 * DEPTH;
    localparam int THR   = DEPTH - 2;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic          wr_req = 1'b1;
    logic [PW-1:0] rd_ptr_gray_async = '0;
    logic          wr_en;
    logic [AW-1:0] waddr;
    logic [PW-1:0] wptr_gray;
    logic          full;
    logic          almost_full;
    logic [PW-1:0] wr_level;

    gray_wptr_gen #(.ADDR_WIDTH(AW), .AFULL_THRESH(THR)) dut (
        .sys_clk           (sys_clk),
        .sys_rst_n         (sys_rst_n),
        .wr_req            (wr_req),
        .rd_ptr_gray_async (rd_ptr_gray_async),
        .wr_en             (wr_en),
        .waddr             (waddr),
        .wptr_gray         (wptr_gray),
        .full              (full),
        .almost_full       (almost_full),
        .wr_level          (wr_level)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: total words written, read count seen at the last two edges.
    int m_wcnt  = 0;
    int m_rcnt  = 0;
    int m_hist0 = 0;
    int m_hist1 = 0;
    int m_lvl   = 0;
    bit m_full  = 1'b0;

    function automatic logic [PW-1:0] to_gray(input int n);
        int m;
        m = n % LAP;
        return PW'(m ^ (m >> 1));
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_wr_en"},   32'(wr_en), 32'd0);
        chk({tag, "_waddr"},   32'(waddr), 32'd0);
        chk({tag, "_gray"},    32'(wptr_gray), 32'd0);
        chk({tag, "_full"},    32'(full), 32'd0);
        chk({tag, "_afull"},   32'(almost_full), 32'd0);
        chk({tag, "_level"},   32'(wr_level), 32'd0);
    endtask

    // One clock cycle: drive at negedge, check accept path, advance model, check registers.
    task automatic step(input bit req, input int rd);
        bit acc;
        @(negedge sys_clk);
        wr_req = req;
        m_rcnt = rd;
        rd_ptr_gray_async = to_gray(rd);
        #1;
        acc = req && !m_full;
        chk("wr_en", 32'(wr_en), 32'(acc));
        chk("waddr", 32'(waddr), 32'(m_wcnt % DEPTH));
        @(posedge sys_clk);
        m_wcnt  = m_wcnt + int'(acc);
        m_lvl   = m_wcnt - m_hist1;
        m_full  = (m_lvl == DEPTH);
        m_hist1 = m_hist0;
        m_hist0 = rd;
        #1;
        chk("wptr_gray",   32'(wptr_gray), 32'(to_gray(m_wcnt)));
        chk("wr_level",    32'(wr_level), 32'(m_lvl));
        chk("full",        32'(full), 32'(m_full));
        chk("almost_full", 32'(almost_full), 32'(m_lvl >= THR));
    endtask

    // Asynchronous reset between edges with wr_req held high; outputs must clear at once.
    task automatic async_reset(input string tag);
        @(negedge sys_clk);
        #2;
        wr_req    = 1'b1;
        sys_rst_n = 1'b0;
        #1;
        chk_zero(tag);
        m_wcnt = 0; m_rcnt = 0; m_hist0 = 0; m_hist1 = 0; m_lvl = 0; m_full = 1'b0;
        rd_ptr_gray_async = '0;
        @(negedge sys_clk);
        wr_req    = 1'b0;
        sys_rst_n = 1'b1;
    endtask

    initial begin
        int nr;
        bit rq;

        // Reset held from time zero with wr_req=1.
        repeat (2) @(posedge sys_clk);
        #1;
        chk_zero("rst");
        @(negedge sys_clk);
        wr_req    = 1'b0;
        sys_rst_n = 1'b1;

        // Fill from empty: gray 001,011,010,110; full after the 4th write.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 0);
        chk("fill_gray",  32'(wptr_gray), 32'd6);
        chk("fill_full",  32'(full), 32'd1);
        chk("fill_level", 32'(wr_level), 32'd4);
        step(1'b1, 0);
        chk("hold_gray",  32'(wptr_gray), 32'd6);

        // Read pointer moves 000->001: full clears only after the third edge.
        step(1'b0, 1);
        chk("rd_n_full", 32'(full), 32'd1);
        step(1'b0, 1);
        chk("rd_n1_full", 32'(full), 32'd1);
        step(1'b0, 1);
        chk("rd_n2_full",  32'(full), 32'd0);
        chk("rd_n2_level", 32'(wr_level), 32'd3);

        // Refill, then read update together with wr_req while full.
        step(1'b1, 1);
        for (int i = 0; i < 4; i++) step(1'b1, 2);
        chk("simul_gray", 32'(wptr_gray), 32'(to_gray(6)));

        // Continuous writes with the reader tracking: wraps without ever going full.
        async_reset("mid");
        for (int i = 0; i < 10; i++) step(1'b1, m_wcnt);
        chk("wrap_gray", 32'(wptr_gray), 32'(to_gray(10)));

        // Advance to wbin=5, then reset asynchronously mid-stream.
        for (int i = 0; i < LAP && (m_wcnt % LAP) != 5; i++) step(1'b1, m_wcnt);
        chk("pre_rst_gray", 32'(wptr_gray), 32'd7);
        async_reset("async");
        step(1'b1, 0);
        chk("restart_gray", 32'(wptr_gray), 32'd1);

        // Randomized traffic: reader never passes the writer, advances one step at a time.
        for (int i = 0; i < 400; i++) begin
            rq = ($urandom_range(0, 9) < 7);
            nr = m_rcnt;
            if (m_rcnt < m_wcnt && $urandom_range(0, 2) == 0) nr = m_rcnt + 1;
            step(rq, nr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
